// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory link: the controller state encoding,
// the frame geometry and the read/write flag values carried in the header.
package spi_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } spi_state_e;

  localparam int   SPI_FRAME_BITS = 16;
  localparam int   SPI_ADDR_BITS  = 7;
  localparam logic SPI_RW_READ    = 1'b1;
  localparam logic SPI_RW_WRITE   = 1'b0;

endpackage

// File: rtl/spi_clkgen.sv
// Half-period timer for the serial clock.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   en          - high while the controller is shifting; low clears the timer
//   rise_tick   - sclk goes high on this clock edge
//   fall_tick   - sclk goes low on this clock edge
// The first rising edge of a frame is produced by the controller itself when
// it enters SHIFT; this block times every edge after that one.
module spi_clkgen #(
  parameter int CLKDIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int            CW   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

  logic [CW-1:0] half_cnt;
  logic          low_phase;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      half_cnt  <= '0;
      low_phase <= 1'b0;
    end else if (half_cnt == LAST) begin
      half_cnt  <= '0;
      low_phase <= ~low_phase;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

  // End of a high phase is a fall; end of a low phase is the next rise.
  assign fall_tick = en && (half_cnt == LAST) && !low_phase;
  assign rise_tick = en && (half_cnt == LAST) && low_phase;

endmodule

// File: rtl/spi_mem_master.sv
// SPI master that runs single-byte read/write frames to the SPI memory slave.
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   req_valid/req_ready - request handshake; accepted when both are high
//   req_rw              - 1 = read, 0 = write
//   req_addr, req_wdata - word address and write data, captured on accept
//   rsp_valid           - one-cycle pulse at the end of every frame
//   rsp_rdata           - read byte (0x00 after a write), held between pulses
//   busy                - high whenever not IDLE
//   sclk, cs, mosi      - SPI outputs (sclk idles low, cs active low)
//   miso                - SPI input, sampled as sclk rises
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | cs high, ready for a request
// SETUP | cs low, first bit on mosi, waiting CLKDIV cycles before first rise
// SHIFT | 16 sclk periods; mosi moves on falls, miso sampled on rises
// GAP   | cs high for 2*CLKDIV cycles so the slave sees a clean deselect
module spi_mem_master
  import spi_mem_pkg::*;
#(
  parameter int CLKDIV = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_rw,
  input  logic [SPI_ADDR_BITS-1:0] req_addr,
  input  logic [7:0]               req_wdata,
  output logic                     rsp_valid,
  output logic [7:0]               rsp_rdata,
  output logic                     busy,
  output logic                     sclk,
  output logic                     cs,
  output logic                     mosi,
  input  logic                     miso
);

  localparam int            TW         = $clog2(2 * CLKDIV);
  localparam logic [TW-1:0] SETUP_LOAD = TW'(CLKDIV - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(2 * CLKDIV - 1);
  localparam logic [4:0]    LAST_BIT   = 5'(SPI_FRAME_BITS);

  spi_state_e                state;
  logic [TW-1:0]             timer;
  logic [4:0]                bit_cnt;
  logic [SPI_FRAME_BITS-1:0] tx_sr;
  logic [7:0]                rx_sr;
  logic                      rw_q;
  logic                      shift_en;
  logic                      rise_tick;
  logic                      fall_tick;

  assign shift_en = (state == SHIFT);

  spi_clkgen #(
    .CLKDIV (CLKDIV)
  ) u_clkgen (
    .clk       (clk),
    .reset     (reset),
    .en        (shift_en),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // The shift register fully drains after 16 falls, so mosi is already 0
  // by the last low phase and stays 0 through GAP and IDLE.
  assign mosi = tx_sr[SPI_FRAME_BITS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= GAP;
      timer     <= GAP_LOAD;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rw_q      <= SPI_RW_WRITE;
      cs        <= 1'b1;
      sclk      <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      busy      <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state     <= SETUP;
            timer     <= SETUP_LOAD;
            bit_cnt   <= '0;
            rw_q      <= req_rw;
            tx_sr     <= {req_addr, req_rw,
                          (req_rw == SPI_RW_WRITE) ? req_wdata : 8'h00};
            cs        <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SETUP: begin
          if (timer == '0) begin
            state   <= SHIFT;
            sclk    <= 1'b1;
            bit_cnt <= 5'd1;
            rx_sr   <= {rx_sr[6:0], miso};
          end else begin
            timer <= timer - 1'b1;
          end
        end
        SHIFT: begin
          if (fall_tick) begin
            sclk  <= 1'b0;
            tx_sr <= {tx_sr[SPI_FRAME_BITS-2:0], 1'b0};
          end else if (rise_tick) begin
            if (bit_cnt == LAST_BIT) begin
              // end of the 16th low phase: close the frame instead of rising
              state     <= GAP;
              timer     <= GAP_LOAD;
              cs        <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_rdata <= (rw_q == SPI_RW_READ) ? rx_sr : 8'h00;
            end else begin
              sclk    <= 1'b1;
              bit_cnt <= bit_cnt + 5'd1;
              rx_sr   <= {rx_sr[6:0], miso};
            end
          end
        end
        GAP: begin
          if (timer == '0) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= GAP;
          timer <= GAP_LOAD;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_mem_master.md
# spi_mem_master

SPI master controller that sequences single-byte read and write transactions to the SPI memory slave. It sits on the host side of the link, between a simple request/response port and the four SPI pins. It generates chip select and a divided serial clock from the FPGA clock, and it enforces setup and gap timing so that the slave's input conditioners and FSM see clean frames.

## Interface
- `CLKDIV`, default 8: clk cycles per sclk half-period; legal range 4..255.
- `clk` in 1: FPGA clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: host request present.
- `req_ready` out 1: controller can accept a request; high only in IDLE.
- `req_rw` in 1: 1 = read, 0 = write.
- `req_addr` in 7: memory word address.
- `req_wdata` in 8: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle pulse at transaction end, for both reads and writes.
- `rsp_rdata` out 8: read data; 0x00 after a write; held until the next `rsp_valid`.
- `busy` out 1: high whenever state is not IDLE.
- `sclk` out 1: SPI clock; idles low.
- `cs` out 1: SPI chip select, active low.
- `mosi` out 1: master out, slave in.
- `miso` in 1: master in, slave out.

## Operation
- Frame is 16 bits, MSB first: `{req_addr[6:0], req_rw}` followed by 8 data bits. For writes the data bits are `req_wdata`. For reads `mosi` is 0 during the data bits.
- All request fields are captured into a 16-bit shift register on accept (`req_valid && req_ready`). Inputs are ignored while the controller is busy.
- States and transitions:
  - IDLE: `cs`=1, `sclk`=0, `req_ready`=1. On accept, go to SETUP.
  - SETUP: `cs`=0, `sclk`=0, `mosi`=frame bit 15. Lasts CLKDIV cycles, then go to SHIFT.
  - SHIFT: 16 bit periods. Each period is `sclk` high for CLKDIV cycles, then low for CLKDIV cycles.
    - `mosi` advances to the next bit on the cycle `sclk` falls.
    - `miso` is sampled into the read shift register on the cycle `sclk` rises.
    - After the 16th low phase, go to GAP.
  - GAP: `cs`=1, `sclk`=0, `mosi`=0, `req_ready`=0. Lasts 2*CLKDIV cycles, then go to IDLE.
- On entry to GAP from SHIFT, `rsp_valid` pulses for one cycle. On that pulse, `rsp_rdata` takes the last 8 sampled `miso` bits for a read, or 0x00 for a write.
- Reset, including mid-frame:
  - Next cycle: state GAP, `cs`=1, `sclk`=0, `mosi`=0, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0x00, `busy`=1.
  - The GAP count restarts, so the slave sees a full deselect before any new frame.
  - An aborted transaction never produces `rsp_valid`.
- Reset applied while `req_valid` is high does not accept the request.

## Timing
- Accept at clock edge n. Then:
  - `cs` is low for cycles n+1 through n+33*CLKDIV.
  - `rsp_valid` is asserted in cycle n+33*CLKDIV+1.
  - `req_ready` is high again in cycle n+35*CLKDIV+1.
- With CLKDIV=8: `cs` low for 264 cycles, response at +265, next accept no earlier than +281.
- `sclk` duty cycle is exactly 50%, with period 2*CLKDIV.
- `mosi` is stable for at least CLKDIV cycles on either side of every `sclk` rising edge.
- `miso` is sampled CLKDIV cycles after the preceding `sclk` fall. The slave drives `miso` from its conditioned falling edge, so CLKDIV must exceed the conditioner latency; hence CLKDIV ≥ 4.
- Counters:
  - Half-period counter: $clog2(CLKDIV) bits, counting 0..CLKDIV-1.
  - Bit counter: 5 bits, counting 0..16.
  - No wrap-around is possible inside a frame.

## Structure
- Shared package `spi_mem_pkg` holds:
  - state enum: IDLE, SETUP, SHIFT, GAP;
  - `SPI_FRAME_BITS` = 16;
  - `SPI_ADDR_BITS` = 7;
  - `SPI_RW_READ` = 1'b1, `SPI_RW_WRITE` = 1'b0.
- Sub-module `spi_clkgen` contains the half-period counter. It emits one-cycle `rise_tick` and `fall_tick` strobes and is cleared whenever the FSM leaves SHIFT.
- The remaining logic stays in `spi_mem_master`: FSM, TX and RX shift registers, and response registers.

## Test plan
- **Write:** CLKDIV=4, write addr 0x15 data 0xA5 → `mosi` bits on `sclk` rises read 0x2A then 0xA5; `rsp_valid` at +133 cycles with `rsp_rdata`=0x00.
- **Read:** slave model drives 0x3C for a read of addr 0x15 → frame header 0x2B; `rsp_rdata`=0x3C on the `rsp_valid` pulse; `mosi`=0 throughout the data bits.
- **End-to-end with spiMemory:** write 0x5A to addr 0x7F, then read addr 0x7F → `rsp_rdata`=0x5A; repeat with addr 0x00 and data 0xFF.
- **Back-to-back:** `req_valid` held high with a second request queued → second accept exactly 35*CLKDIV+1 cycles after the first; `cs` high for 2*CLKDIV cycles between frames.
- **Input isolation:** `req_addr` and `req_wdata` changed mid-frame → transmitted frame unchanged; `req_ready`=0 and `busy`=1 throughout.
- **Reset mid-frame:** `reset` asserted after the 5th `sclk` rise → next cycle `cs`=1, `sclk`=0, `mosi`=0; no `rsp_valid`; `req_ready` returns exactly 2*CLKDIV cycles after `reset` deasserts.
